// File: rtl/slot_scheduler.sv
// Round-robin slot scheduler: grants one requester at a time for at most SLOT
// enabled cycles, then inserts a one-cycle gap before re-arbitrating.
module slot_scheduler #(
    parameter int N_REQ = 4,
    parameter int SLOT  = 8,
    parameter int WIDTH = (SLOT > 1) ? $clog2(SLOT) : 1,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic [WIDTH-1:0] slot_cnt,
    output logic             expire
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] SLOT_LAST = WIDTH'(SLOT - 1);
    localparam logic [IDW-1:0]   ID_LAST   = IDW'(N_REQ - 1);

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]   slot_cnt_q, slot_cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic               expire_q, expire_d;

    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic [IDW-1:0]     ptr_after_owner;

    // Returns {found, index} of the first set request at or above ptr, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [IDW-1:0] ptr,
                                             input logic [N_REQ-1:0] r);
        logic [IDW:0] result;
        int idx;
        result = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!result[IDW] && r[IDW'(idx)]) begin
                result = {1'b1, IDW'(idx)};
            end
        end
        return result;
    endfunction

    always_comb begin
        {win_found, win_idx} = rr_pick(ptr_q, req);
        ptr_after_owner = (gnt_id_q == ID_LAST) ? '0 : gnt_id_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        slot_cnt_d = slot_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        expire_d   = 1'b0;
        if (ce) begin
            case (state_q)
                IDLE, GAP: begin
                    if (win_found) begin
                        state_d         = GRANT;
                        gnt_d           = '0;
                        gnt_d[win_idx]  = 1'b1;
                        gnt_id_d        = win_idx;
                        slot_cnt_d      = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                GRANT: begin
                    // A dropped request wins over a coincident timeout, so no expire.
                    if (!req[gnt_id_q] || slot_cnt_q == SLOT_LAST) begin
                        state_d    = GAP;
                        gnt_d      = '0;
                        ptr_d      = ptr_after_owner;
                        slot_cnt_d = '0;
                        expire_d   = req[gnt_id_q];
                    end else begin
                        slot_cnt_d = slot_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    slot_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            slot_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            expire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            slot_cnt_q <= slot_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            expire_q   <= expire_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = gnt_id_q;
    assign busy     = (state_q == GRANT);
    assign slot_cnt = slot_cnt_q;
    assign expire   = expire_q;

endmodule

// File: tb/tb_slot_scheduler.sv
// Self-checking bench for slot_scheduler (N_REQ=4, SLOT=4): fixed vector table,
// directed corner sequences and randomized traffic against a behavioural model.
module tb_slot_scheduler;

    localparam int N = 4;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce  = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [1:0] slot_cnt;
    logic       expire;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the resource, for how long, and where the search starts.
    int m_owner;
    int m_cnt;
    int m_ptr;
    bit m_expire;

    slot_scheduler #(.N_REQ(N), .SLOT(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .slot_cnt (slot_cnt),
        .expire   (expire)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ce;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       busy;
        int         cnt;
        int         id;
        logic       expire;
    } vec_t;

    vec_t tbl[22];

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rr_winner(input int from, input logic [3:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner  = -1;
        m_cnt    = 0;
        m_ptr    = 0;
        m_expire = 1'b0;
    endfunction

    function automatic void model_end_grant();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
    endfunction

    function automatic void model_step(input logic c, input logic [3:0] r);
        int w;
        m_expire = 1'b0;
        if (!c) return;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                model_end_grant();
            end else if (m_cnt == S - 1) begin
                model_end_grant();
                m_expire = 1'b1;
            end else begin
                m_cnt++;
            end
        end else begin
            w = rr_winner(m_ptr, r);
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 0;
            end
        end
    endfunction

    task automatic compare_model();
        int exp_gnt;
        exp_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
        check_val("model_gnt", int'(gnt), exp_gnt);
        check_val("model_busy", int'(busy), (m_owner >= 0) ? 1 : 0);
        check_val("model_slot_cnt", int'(slot_cnt), m_cnt);
        check_val("model_expire", int'(expire), int'(m_expire));
        check_val("gnt_onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
        if (m_owner >= 0) begin
            check_val("model_gnt_id", int'(gnt_id), m_owner);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic [3:0] r);
        ce  = c;
        req = r;
        @(posedge clk);
        model_step(c, r);
        #1;
        compare_model();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #2;
        model_reset();
        check_val("rst_gnt", int'(gnt), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_slot_cnt", int'(slot_cnt), 0);
        check_val("rst_expire", int'(expire), 0);
        check_val("rst_gnt_id", int'(gnt_id), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int grant_order[$];
        int grant_len[$];
        int expire_seen;
        int run_len;
        logic prev_busy;
        logic [3:0] rnd_req;

        model_reset();
        //              ce    req      gnt     busy cnt id exp
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0};
        tbl[1]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 0, 1, 1'b0};
        tbl[2]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 1, 1, 1'b0};
        tbl[3]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 2, 1, 1'b0};
        tbl[4]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 2, 1, 1'b0};
        tbl[5]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 2, 1, 1'b0};
        tbl[6]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 2, 1, 1'b0};
        tbl[7]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 3, 1, 1'b0};
        tbl[8]  = '{1'b1, 4'b0010, 4'b0000, 1'b0, 0, 0, 1'b1};
        tbl[9]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 0, 1, 1'b0};
        tbl[10] = '{1'b1, 4'b0011, 4'b0010, 1'b1, 1, 1, 1'b0};
        tbl[11] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 0, 0, 1'b0};
        tbl[12] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 0, 0, 1'b0};
        tbl[13] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 1, 0, 1'b0};
        tbl[14] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 2, 0, 1'b0};
        tbl[15] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 3, 0, 1'b0};
        tbl[16] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0};
        tbl[17] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 0, 0, 1'b0};
        tbl[18] = '{1'b1, 4'b0101, 4'b0100, 1'b1, 0, 2, 1'b0};
        tbl[19] = '{1'b1, 4'b0101, 4'b0100, 1'b1, 1, 2, 1'b0};
        tbl[20] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 0, 0, 1'b0};
        tbl[21] = '{1'b1, 4'b0101, 4'b0001, 1'b1, 0, 0, 1'b0};

        apply_reset();
        for (int i = 0; i < 22; i++) begin
            applyStimulus(tbl[i].ce, tbl[i].req);
            check_val($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
            check_val($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
            check_val($sformatf("tbl%0d_cnt", i), int'(slot_cnt), tbl[i].cnt);
            check_val($sformatf("tbl%0d_expire", i), int'(expire), int'(tbl[i].expire));
            if (tbl[i].busy) begin
                check_val($sformatf("tbl%0d_id", i), int'(gnt_id), tbl[i].id);
            end
        end

        // All four requesting: rotation 0,1,2,3,0 with full-length grants.
        apply_reset();
        expire_seen = 0;
        run_len     = 0;
        prev_busy   = 1'b0;
        for (int cyc = 0; cyc < 60 && grant_order.size() < 5; cyc++) begin
            applyStimulus(1'b1, 4'b1111);
            if (expire) expire_seen++;
            if (busy && !prev_busy) begin
                grant_order.push_back(int'(gnt_id));
                run_len = 0;
            end
            if (busy) run_len++;
            if (!busy && prev_busy) grant_len.push_back(run_len);
            prev_busy = busy;
        end
        check_val("rotation_grants_seen", grant_order.size(), 5);
        for (int i = 0; i < grant_order.size(); i++) begin
            check_val($sformatf("rotation_order%0d", i), grant_order[i], i % N);
        end
        for (int i = 0; i < grant_len.size(); i++) begin
            check_val($sformatf("rotation_len%0d", i), grant_len[i], S);
        end
        check_val("rotation_expires", expire_seen, 4);

        // Asynchronous reset mid-grant, then arbitration restarts at index 0.
        apply_reset();
        applyStimulus(1'b1, 4'b0100);
        applyStimulus(1'b1, 4'b0100);
        applyStimulus(1'b1, 4'b0100);
        check_val("midrst_cnt_before", int'(slot_cnt), 2);
        #2;
        rst = 1'b0;
        #1;
        check_val("midrst_gnt", int'(gnt), 0);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_expire", int'(expire), 0);
        model_reset();
        req = 4'b1100;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 4'b1100);
        check_val("midrst_winner", int'(gnt_id), 2);
        check_val("midrst_gnt_after", int'(gnt), 4);

        // Randomized traffic against the model, with occasional resets.
        apply_reset();
        rnd_req = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 3) == 0) rnd_req = 4'($urandom);
            if ($urandom_range(0, 299) == 0) apply_reset();
            applyStimulus($urandom_range(0, 9) != 0, rnd_req);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
